mf_cegen_multi: RTL and testbench
=================================

// Module: mf_cegen_multi
// PURPOSE
//   Parametrised multi-channel fractional clock-enable generator.
//   - One phase accumulator (NCO) per channel in the refclk domain.
//   - Each channel emits single-cycle enable pulses at refclk * INC / 2^ACC_W, with a programmable phase offset.
//   - Replaces extra PLL outputs (e.g. 21.47727 MHz, 10.738635 MHz, phase-shifted copies) with enables derived from one PLL clock.
//   - Runtime-reprogrammable; reports lock after a settling window.
// PARAMETERS
//   NUM_CH       4      number of enable channels, 1..16
//   ACC_W        32     accumulator width in bits, 8..48
//   LOCK_CYCLES  16     refclk cycles from reset/reload until locked, >= 1
// PORTS
//   refclk      in   1              system clock; all logic is in this domain
//   rst         in   1              synchronous reset, active-high
//   cfg_load    in   1              1-cycle strobe: latch cfg_inc/cfg_phase, restart channels
//   cfg_inc     in   NUM_CH*ACC_W   per-channel increment, channel i at [i*ACC_W +: ACC_W]
//   cfg_phase   in   NUM_CH*ACC_W   per-channel start phase, same packing
//   ce          out  NUM_CH         per-channel enable pulse, registered
//   locked      out  1              enables valid; ce forced 0 while low
// BEHAVIOUR
//   - Reset (rst=1 at a refclk edge):
//     - inc_q[i] <= 0; acc[i] <= 0; ce <= 0; locked <= 0; lock_cnt <= 0.
//     - Generator stays idle until the first cfg_load.
//   - cfg_load=1 (rst=0):
//     - inc_q[i] <= cfg_inc[i]; acc[i] <= cfg_phase[i]; ce <= 0; locked <= 0; lock_cnt <= 0.
//     - cfg_load held high for several cycles: reload repeats each cycle, lock window restarts each cycle.
//   - Normal cycle (rst=0, cfg_load=0):
//     - sum = {1'b0, acc[i]} + {1'b0, inc_q[i]}, width ACC_W+1; acc[i] <= sum[ACC_W-1:0] (mod 2^ACC_W).
//     - ce[i] <= sum[ACC_W] & locked. Accumulators run during the lock window; only ce is gated.
//   - Lock counter:
//     - Saturating 0..LOCK_CYCLES, increments while !locked and inc_q is nonzero on any channel.
//     - locked <= 1 on the cycle lock_cnt reaches LOCK_CYCLES-1; stays set until rst or cfg_load.
//   - Latency:
//     - ce[i] is high the cycle after the edge where acc[i] wraps.
//     - First pulse after reload occurs when phase + k*inc >= 2^ACC_W, provided locked is already 1.
//   - Boundaries:
//     - inc=0: channel never pulses.
//     - inc=2^ACC_W-1: pulses on every cycle except once per 2^ACC_W cycles.
//     - All-zero cfg_inc: locked never asserts.
//   - Priority: rst > cfg_load > normal.
//   - Channels are independent; no cross-channel arbitration. Long-run average rate is exact with no drift.
// CONFIGURATION
//   - Macro CEGEN_TOGGLE_EN.
//   - Defined:
//     - Adds output clk_sq [NUM_CH], registered.
//     - clk_sq[i] toggles on every ce[i] pulse, giving a ~50% square wave at half the ce rate.
//     - Reset and cfg_load set clk_sq to 0.
//   - Undefined: clk_sq port and its logic are absent; all other behaviour is identical.
// TESTING
//   ACC_W=32, NUM_CH=4, LOCK_CYCLES=16 unless stated otherwise.
//   1. Basic rates:
//      - Stimulus: load inc = {0x40000000, 0x20000000, 0x20000000, 0}, phase=0.
//      - Response: locked rises 16 cycles after load. After lock, ch0 pulses every 4 cycles, ch1/ch2 every 8, ch3 never.
//   2. Phase offset:
//      - Stimulus: ch1 and ch2 inc=0x20000000; ch1 phase=0, ch2 phase=0x80000000.
//      - Response: ch2 pulses exactly 4 cycles before ch1, both at period 8.
//   3. Fractional rate:
//      - Stimulus: inc=0x55555555.
//      - Response: over 3000 locked cycles, exactly 1000 pulses (+/-1); pulse gaps only 2 or 3 cycles.
//   4. Reset mid-operation:
//      - Stimulus: assert rst for 1 cycle while running.
//      - Response: next cycle ce=0 and locked=0; no pulse until a new cfg_load plus 16 cycles.
//   5. Reload while running:
//      - Stimulus: cfg_load with a new inc, simultaneous with a pending wrap.
//      - Response: that wrap produces no pulse; locked=0 for 16 cycles; new rate follows.
//   6. CEGEN_TOGGLE_EN:
//      - Stimulus: inc=0x40000000.
//      - Response: clk_sq period is 8 cycles (4 high, 4 low). Repeat the build with the macro undefined: elaboration succeeds with no clk_sq port.

Source files
------------

// File: rtl/mf_cegen_multi.sv
// Multi-channel fractional clock-enable generator: one NCO per channel, gated by a lock window.
// Optional CEGEN_TOGGLE_EN adds a per-channel square-wave output clk_sq that toggles on each ce pulse.
module mf_cegen_multi #(
   parameter int NUM_CH      = 4,
   parameter int ACC_W       = 32,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                    refclk,
   input  logic                    rst,
   input  logic                    cfg_load,
   input  logic [NUM_CH*ACC_W-1:0] cfg_inc,
   input  logic [NUM_CH*ACC_W-1:0] cfg_phase,
   output logic [NUM_CH-1:0]       ce,
`ifdef CEGEN_TOGGLE_EN
   output logic [NUM_CH-1:0]       clk_sq,
`endif
   output logic                    locked
);

   localparam int LC_W = $clog2(LOCK_CYCLES + 1);

   logic [ACC_W-1:0] acc   [NUM_CH];
   logic [ACC_W-1:0] inc_q [NUM_CH];
   logic [ACC_W:0]   sum   [NUM_CH];
   logic [NUM_CH-1:0] carry;
   logic [NUM_CH-1:0] pulse;
   logic              any_nz;
   logic [LC_W-1:0]   lock_cnt;

   always_comb begin
      any_nz = 1'b0;
      carry  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum[i]   = {1'b0, acc[i]} + {1'b0, inc_q[i]};
         carry[i] = sum[i][ACC_W];
         any_nz   = any_nz | (|inc_q[i]);
      end
      pulse = carry & {NUM_CH{locked}};
   end

   // Accumulators keep running through the lock window; only the enables are gated.
   always_ff @(posedge refclk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            inc_q[i] <= '0;
            acc[i]   <= '0;
         end
         ce <= '0;
      end else if (cfg_load) begin
         for (int i = 0; i < NUM_CH; i++) begin
            inc_q[i] <= cfg_inc[i*ACC_W +: ACC_W];
            acc[i]   <= cfg_phase[i*ACC_W +: ACC_W];
         end
         ce <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= sum[i][ACC_W-1:0];
         end
         ce <= pulse;
      end
   end

   // An all-zero configuration never settles, so lock is only counted while some channel runs.
   always_ff @(posedge refclk) begin
      if (rst || cfg_load) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (!locked && any_nz) begin
         if (lock_cnt == LC_W'(LOCK_CYCLES - 1)) begin
            locked <= 1'b1;
         end
         if (lock_cnt != LC_W'(LOCK_CYCLES)) begin
            lock_cnt <= lock_cnt + LC_W'(1);
         end
      end
   end

`ifdef CEGEN_TOGGLE_EN
   always_ff @(posedge refclk) begin
      if (rst || cfg_load) begin
         clk_sq <= '0;
      end else begin
         clk_sq <= clk_sq ^ pulse;
      end
   end
`endif

endmodule

// File: tb/tb_mf_cegen_multi.sv
// Self-checking bench for mf_cegen_multi; the reference model computes wraps from phase + k*inc arithmetic.
module tb_mf_cegen_multi;

   localparam int NCH = 4;
   localparam int W   = 32;
   localparam int LC  = 16;

   logic             refclk;
   logic             rst;
   logic             cfg_load;
   logic [NCH*W-1:0] cfg_inc;
   logic [NCH*W-1:0] cfg_phase;
   logic [NCH-1:0]   ce;
   logic             locked;
`ifdef CEGEN_TOGGLE_EN
   logic [NCH-1:0]   clk_sq;
`endif

   int checks;
   int failures;

   longint unsigned m_inc [NCH];
   longint unsigned m_ph  [NCH];
   longint unsigned m_k;
   logic [NCH-1:0]  m_sq;

   mf_cegen_multi #(.NUM_CH(NCH), .ACC_W(W), .LOCK_CYCLES(LC)) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_load  (cfg_load),
      .cfg_inc   (cfg_inc),
      .cfg_phase (cfg_phase),
      .ce        (ce),
`ifdef CEGEN_TOGGLE_EN
      .clk_sq    (clk_sq),
`endif
      .locked    (locked)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Channel ch crosses a multiple of 2^W between cycle k-1 and k after load.
   function automatic bit exp_wrap(int ch, longint unsigned k);
      longint unsigned a, b;
      if (k == 0) return 1'b0;
      a = (m_ph[ch] + (k - 1) * m_inc[ch]) >> W;
      b = (m_ph[ch] + k * m_inc[ch]) >> W;
      return a != b;
   endfunction

   function automatic bit exp_any();
      bit r = 1'b0;
      for (int ch = 0; ch < NCH; ch++) if (m_inc[ch] != 0) r = 1'b1;
      return r;
   endfunction

   function automatic logic exp_locked();
      return exp_any() && (m_k >= LC);
   endfunction

   function automatic logic [NCH-1:0] exp_ce();
      logic [NCH-1:0] v = '0;
      for (int ch = 0; ch < NCH; ch++)
         v[ch] = exp_wrap(ch, m_k) && exp_any() && (m_k >= LC + 1);
      return v;
   endfunction

   task automatic tick(input bit ld, input bit r, input logic [NCH*W-1:0] inc, input logic [NCH*W-1:0] ph);
      rst       = r;
      cfg_load  = ld;
      cfg_inc   = inc;
      cfg_phase = ph;
      @(posedge refclk);
      #1;
      if (r) begin
         for (int ch = 0; ch < NCH; ch++) begin
            m_inc[ch] = 0;
            m_ph[ch]  = 0;
         end
         m_k  = 0;
         m_sq = '0;
      end else if (ld) begin
         for (int ch = 0; ch < NCH; ch++) begin
            m_inc[ch] = longint'(inc[ch*W +: W]);
            m_ph[ch]  = longint'(ph[ch*W +: W]);
         end
         m_k  = 0;
         m_sq = '0;
      end else begin
         m_k++;
         m_sq = m_sq ^ exp_ce();
      end
      rst      = 1'b0;
      cfg_load = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, '0, '0);
         checks++;
         if (ce !== 4'b0000 || locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state ce=%b locked=%b required ce=0000 locked=0", ce, locked);
         end
      end
      for (int i = 0; i < 25; i++) begin
         tick(0, 0, '0, '0);
         checks++;
         if (ce !== 4'b0000 || locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset cyc=%0d ce=%b locked=%b required 0000/0", i, ce, locked);
         end
      end
   endtask

   task automatic test_basic_rates();
      logic [NCH*W-1:0] inc;
      int lock_at = -1;
      int cnt [NCH] = '{default: 0};
      inc = {32'h0, 32'h2000_0000, 32'h2000_0000, 32'h4000_0000};
      tick(1, 0, inc, '0);
      for (int i = 0; i < 80; i++) begin
         tick(0, 0, inc, '0);
         checks++;
         if (ce !== exp_ce() || locked !== exp_locked()) begin
            failures++;
            $display("[TB] FAIL basic_rates k=%0d ce=%b locked=%b required %b/%b", m_k, ce, locked, exp_ce(), exp_locked());
         end
         if (locked === 1'b1 && lock_at < 0) lock_at = int'(m_k);
         for (int ch = 0; ch < NCH; ch++) if (ce[ch] === 1'b1) cnt[ch]++;
      end
      checks++;
      if (lock_at != LC) begin
         failures++;
         $display("[TB] FAIL lock_latency got=%0d required=%0d", lock_at, LC);
      end
      // Pulses at k=20,24,...,80 for ch0 and k=24,32,...,80 for ch1/ch2.
      checks++;
      if (cnt[0] != 16 || cnt[1] != 8 || cnt[2] != 8 || cnt[3] != 0) begin
         failures++;
         $display("[TB] FAIL basic_counts got=%0d/%0d/%0d/%0d required=16/8/8/0", cnt[0], cnt[1], cnt[2], cnt[3]);
      end
   endtask

   task automatic test_phase_offset();
      logic [NCH*W-1:0] inc, ph;
      longint last1 = -1, last2 = -1;
      inc = {32'h0, 32'h2000_0000, 32'h2000_0000, 32'h0};
      ph  = {32'h0, 32'h8000_0000, 32'h0, 32'h0};
      tick(1, 0, inc, ph);
      for (int i = 0; i < 70; i++) begin
         tick(0, 0, inc, ph);
         checks++;
         if (ce !== exp_ce() || locked !== exp_locked()) begin
            failures++;
            $display("[TB] FAIL phase_model k=%0d ce=%b locked=%b required %b/%b", m_k, ce, locked, exp_ce(), exp_locked());
         end
         if (ce[2] === 1'b1) last2 = longint'(m_k);
         if (ce[1] === 1'b1) begin
            checks++;
            if (last2 < 0 || longint'(m_k) - last2 != 4 || (last1 >= 0 && longint'(m_k) - last1 != 8)) begin
               failures++;
               $display("[TB] FAIL phase_offset k=%0d last_ch2=%0d last_ch1=%0d required lead 4 period 8", m_k, last2, last1);
            end
            last1 = longint'(m_k);
         end
      end
   endtask

   task automatic test_fractional();
      logic [NCH*W-1:0] inc, ph;
      int pulses = 0, bad_gap = 0, last = -1, waited = 0;
      inc = {$urandom(), $urandom(), $urandom(), 32'h5555_5555};
      ph  = {$urandom(), $urandom(), $urandom(), 32'h0};
      tick(1, 0, inc, ph);
      while (locked !== 1'b1 && waited < 40) begin
         tick(0, 0, inc, ph);
         waited++;
      end
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("[TB] FAIL frac_lock_timeout locked=%b required 1", locked);
      end
      for (int i = 0; i < 3000; i++) begin
         tick(0, 0, inc, ph);
         checks++;
         if (ce !== exp_ce() || locked !== exp_locked()) begin
            failures++;
            $display("[TB] FAIL frac_model k=%0d ce=%b locked=%b required %b/%b", m_k, ce, locked, exp_ce(), exp_locked());
         end
         if (ce[0] === 1'b1) begin
            pulses++;
            if (last >= 0 && (i - last < 2 || i - last > 3)) bad_gap++;
            last = i;
         end
      end
      checks++;
      if (pulses < 999 || pulses > 1001 || bad_gap != 0) begin
         failures++;
         $display("[TB] FAIL frac_rate pulses=%0d bad_gaps=%0d required 1000+/-1 and 0", pulses, bad_gap);
      end
   endtask

   task automatic test_random_boundaries();
      logic [NCH*W-1:0] inc, ph;
      for (int cfg = 0; cfg < 8; cfg++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            case ($urandom_range(0, 4))
               0:       inc[ch*W +: W] = 32'h0;
               1:       inc[ch*W +: W] = 32'hFFFF_FFFF;
               2:       inc[ch*W +: W] = 32'h8000_0000;
               3:       inc[ch*W +: W] = $urandom() >> $urandom_range(0, 8);
               default: inc[ch*W +: W] = $urandom();
            endcase
            ph[ch*W +: W] = $urandom();
         end
         if (cfg == 0) inc = '0;
         if (cfg == 1) inc = {NCH{32'hFFFF_FFFF}};
         tick(1, 0, inc, ph);
         for (int i = 0; i < 60; i++) begin
            tick(0, 0, inc, ph);
            checks++;
            if (ce !== exp_ce() || locked !== exp_locked()) begin
               failures++;
               $display("[TB] FAIL random_cfg%0d k=%0d ce=%b locked=%b required %b/%b", cfg, m_k, ce, locked, exp_ce(), exp_locked());
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [NCH*W-1:0] inc;
      inc = {NCH{32'h4000_0000}};
      tick(1, 0, inc, '0);
      for (int i = 0; i < 30; i++) tick(0, 0, inc, '0);
      tick(0, 1, inc, '0);
      checks++;
      if (ce !== 4'b0000 || locked !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid ce=%b locked=%b required 0000/0", ce, locked);
      end
      for (int i = 0; i < 30; i++) begin
         tick(0, 0, inc, '0);
         checks++;
         if (ce !== 4'b0000 || locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_idle cyc=%0d ce=%b locked=%b required 0000/0", i, ce, locked);
         end
      end
      tick(1, 0, inc, '0);
      for (int i = 0; i < 30; i++) begin
         tick(0, 0, inc, '0);
         checks++;
         if (ce !== exp_ce() || locked !== exp_locked()) begin
            failures++;
            $display("[TB] FAIL reset_mid_reload k=%0d ce=%b locked=%b required %b/%b", m_k, ce, locked, exp_ce(), exp_locked());
         end
      end
   endtask

   task automatic test_reload_running();
      logic [NCH*W-1:0] inc, inc2;
      inc  = {32'h0, 32'h0, 32'h0, 32'h4000_0000};
      inc2 = {32'h0, 32'h0, 32'h0, 32'h2000_0000};
      tick(1, 0, inc, '0);
      for (int i = 0; i < 31; i++) tick(0, 0, inc, '0);
      // The next edge would wrap ch0; reload lands on it instead.
      tick(1, 0, inc2, '0);
      checks++;
      if (ce !== 4'b0000 || locked !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reload_wrap_suppressed ce=%b locked=%b required 0000/0", ce, locked);
      end
      for (int i = 0; i < 50; i++) begin
         tick(0, 0, inc2, '0);
         checks++;
         if (ce !== exp_ce() || locked !== exp_locked()) begin
            failures++;
            $display("[TB] FAIL reload_model k=%0d ce=%b locked=%b required %b/%b", m_k, ce, locked, exp_ce(), exp_locked());
         end
      end
   endtask

   task automatic test_load_held();
      logic [NCH*W-1:0] inc;
      inc = {32'h1234_5678, 32'h4000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      for (int i = 0; i < 20; i++) begin
         tick(1, 0, inc, '0);
         checks++;
         if (ce !== 4'b0000 || locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_held cyc=%0d ce=%b locked=%b required 0000/0", i, ce, locked);
         end
      end
      for (int i = 0; i < 40; i++) begin
         tick(0, 0, inc, '0);
         checks++;
         if (ce !== exp_ce() || locked !== exp_locked()) begin
            failures++;
            $display("[TB] FAIL load_held_release k=%0d ce=%b locked=%b required %b/%b", m_k, ce, locked, exp_ce(), exp_locked());
         end
      end
   endtask

`ifdef CEGEN_TOGGLE_EN
   task automatic test_toggle();
      logic [NCH*W-1:0] inc;
      longint last_rise = -1;
      logic   prev = 1'b0;
      inc = {32'h0, 32'h2000_0000, 32'h8000_0000, 32'h4000_0000};
      tick(1, 0, inc, '0);
      for (int i = 0; i < 80; i++) begin
         tick(0, 0, inc, '0);
         checks++;
         if (clk_sq !== m_sq) begin
            failures++;
            $display("[TB] FAIL clk_sq_model k=%0d clk_sq=%b required %b", m_k, clk_sq, m_sq);
         end
         if (clk_sq[0] === 1'b1 && prev === 1'b0) begin
            if (last_rise >= 0) begin
               checks++;
               if (longint'(m_k) - last_rise != 8) begin
                  failures++;
                  $display("[TB] FAIL clk_sq_period got=%0d required=8", longint'(m_k) - last_rise);
               end
            end
            last_rise = longint'(m_k);
         end
         prev = clk_sq[0];
      end
   endtask
`endif

   initial begin
      checks    = 0;
      failures  = 0;
      m_k       = 0;
      m_sq      = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         m_inc[ch] = 0;
         m_ph[ch]  = 0;
      end
      rst       = 1'b1;
      cfg_load  = 1'b0;
      cfg_inc   = '0;
      cfg_phase = '0;
      test_reset();
      test_basic_rates();
      test_phase_offset();
      test_fractional();
      test_random_boundaries();
      test_reset_mid();
      test_reload_running();
      test_load_held();
`ifdef CEGEN_TOGGLE_EN
      test_toggle();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
